// File: rtl/msg_queue.sv
// rtl/msg_queue.sv - parser output message FIFO with ready/valid head, overflow and error-discard counters
module msg_queue #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DEPTH         = 4,
    parameter bit DROP_ERRORED  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [15:0]                in_length,
    input  logic [8*MAX_MSG_BYTES-1:0] in_data,
    input  logic                       in_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_length,
    output logic [8*MAX_MSG_BYTES-1:0] out_data,
    output logic                       out_error,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic [15:0]                err_drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 8 * MAX_MSG_BYTES;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    typedef struct packed {
        logic [15:0]   length;
        logic [DW-1:0] data;
        logic          error;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_entry;
    entry_t        head_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          err_discard;
    logic          slot_avail;
    logic          push;
    logic          pop;
    logic          drop;

    // Bytes beyond the declared length are zeroed; bad lengths are flagged but kept intact.
    always_comb begin
        in_entry        = '0;
        in_entry.length = in_length;
        in_entry.error  = in_error || (in_length == 16'd0) || (in_length > 16'(MAX_MSG_BYTES));
        for (int i = 0; i < MAX_MSG_BYTES; i++) begin
            in_entry.data[8*i +: 8] = (i < int'(in_length)) ? in_data[8*i +: 8] : 8'h00;
        end
    end

    assign full        = (count == DEPTH_C);
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign err_discard = DROP_ERRORED && in_valid && in_error;
    assign slot_avail  = !full || pop;
    assign push        = in_valid && !err_discard && slot_avail;
    assign drop        = in_valid && !err_discard && !slot_avail;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            head_q         <= '0;
            overflow       <= 1'b0;
            drop_count     <= '0;
            err_drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase

            // Head registers mirror mem[rd_ptr]; with one entry left, a same-cycle push becomes the new head.
            if (pop) begin
                if (count > ONE_C) head_q <= mem[rd_ptr + 1'b1];
                else if (push)     head_q <= in_entry;
                else               head_q <= '0;
            end else if (push && count == '0) begin
                head_q <= in_entry;
            end

            overflow <= drop;
            if (drop && drop_count != 16'hFFFF)            drop_count     <= drop_count + 16'd1;
            if (err_discard && err_drop_count != 16'hFFFF) err_drop_count <= err_drop_count + 16'd1;
        end
    end

    assign out_length = head_q.length;
    assign out_data   = head_q.data;
    assign out_error  = head_q.error;
    assign occupancy  = count;
endmodule

// File: tb/tb_msg_queue.sv
// tb/tb_msg_queue.sv - self-checking bench for msg_queue against a queue-based message model
module tb_msg_queue;
    localparam int MB  = 32;
    localparam int DEP = 4;
    localparam int DW  = 8 * MB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_length = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_error = 1'b0;
    logic          out_ready = 1'b0;

    logic          out_valid, out_error, full, overflow;
    logic [15:0]   out_length, drop_count, err_drop_count;
    logic [DW-1:0] out_data;
    logic [2:0]    occupancy;

    logic          e_out_valid, e_out_error, e_full, e_overflow;
    logic [15:0]   e_out_length, e_drop_count, e_err_drop_count;
    logic [DW-1:0] e_out_data;
    logic [2:0]    e_occupancy;

    always #5 clk = ~clk;

    msg_queue #(.MAX_MSG_BYTES(MB), .DEPTH(DEP), .DROP_ERRORED(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_length(in_length), .in_data(in_data),
        .in_error(in_error), .out_valid(out_valid), .out_ready(out_ready), .out_length(out_length),
        .out_data(out_data), .out_error(out_error), .occupancy(occupancy), .full(full),
        .overflow(overflow), .drop_count(drop_count), .err_drop_count(err_drop_count)
    );

    msg_queue #(.MAX_MSG_BYTES(MB), .DEPTH(DEP), .DROP_ERRORED(1'b1)) dut_de (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_length(in_length), .in_data(in_data),
        .in_error(in_error), .out_valid(e_out_valid), .out_ready(1'b1), .out_length(e_out_length),
        .out_data(e_out_data), .out_error(e_out_error), .occupancy(e_occupancy), .full(e_full),
        .overflow(e_overflow), .drop_count(e_drop_count), .err_drop_count(e_err_drop_count)
    );

    typedef struct {
        logic [15:0]   len;
        logic [DW-1:0] data;
        logic          err;
    } msg_t;

    msg_t q[$];
    logic exp_ovf = 1'b0;
    int   exp_drops = 0;
    int   exp_edrops = 0;
    logic stalled = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [15:0]   prev_len;
    logic [DW-1:0] prev_data;
    logic          prev_err;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic msg_t clean(input logic [15:0] len, input logic [DW-1:0] d, input logic e);
        msg_t m;
        logic [DW-1:0] mask;
        if (int'(len) >= MB) mask = '1;
        else                 mask = (DW'(1) << (8 * int'(len))) - DW'(1);
        m.len  = len;
        m.data = d & mask;
        m.err  = e || (len == 16'd0) || (int'(len) > MB);
        return m;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    // Reference model: pop the head if accepted, then queue the message if a slot exists.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            exp_ovf    = 1'b0;
            exp_drops  = 0;
            exp_edrops = 0;
            stalled    = 1'b0;
        end else begin
            bit pop_m;
            bit slot_m;
            stalled = (q.size() > 0) && !out_ready;
            pop_m   = (q.size() > 0) && out_ready;
            slot_m  = (q.size() < DEP) || pop_m;
            if (pop_m) void'(q.pop_front());
            exp_ovf = 1'b0;
            if (in_valid) begin
                if (in_error && exp_edrops < 65535) exp_edrops++;
                if (slot_m) q.push_back(clean(in_length, in_data, in_error));
                else begin
                    exp_ovf = 1'b1;
                    if (exp_drops < 65535) exp_drops++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_length", DW'(out_length), DW'(q[0].len));
                chk("out_data", out_data, q[0].data);
                chk("out_error", DW'(out_error), DW'(q[0].err));
            end
            chk("occupancy", DW'(occupancy), DW'(q.size()));
            chk("full", DW'(full), DW'(q.size() == DEP));
            chk("overflow", DW'(overflow), DW'(exp_ovf));
            chk("drop_count", DW'(drop_count), DW'(exp_drops));
            chk("err_drop_count", DW'(err_drop_count), DW'(0));
            chk("de_err_drop_count", DW'(e_err_drop_count), DW'(exp_edrops));
            chk("de_drop_count", DW'(e_drop_count), DW'(0));
            if (stalled) begin
                chk("stall_length", DW'(out_length), DW'(prev_len));
                chk("stall_data", out_data, prev_data);
                chk("stall_error", DW'(out_error), DW'(prev_err));
            end
            prev_len  = out_length;
            prev_data = out_data;
            prev_err  = out_error;
        end
    end

    task automatic send(input logic [15:0] len, input logic [DW-1:0] d, input logic e);
        in_valid  = 1'b1;
        in_length = len;
        in_data   = d;
        in_error  = e;
        @(negedge clk);
        in_valid  = 1'b0;
        in_error  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;
        logic [15:0]   t3_exp [4];
        int            sent;

        repeat (2) @(negedge clk);
        chk("reset_valid", DW'(out_valid), DW'(0));
        chk("reset_length", DW'(out_length), DW'(0));
        chk("reset_data", out_data, DW'(0));
        chk("reset_occupancy", DW'(occupancy), DW'(0));
        chk("reset_drop_count", DW'(drop_count), DW'(0));
        rst = 1'b1;
        @(negedge clk);

        // Single message, junk above the declared length
        out_ready = 1'b1;
        d = rnd_data();
        d[39:0] = 40'h0504030201;
        send(16'd5, d, 1'b0);
        chk("t1_valid", DW'(out_valid), DW'(1));
        chk("t1_length", DW'(out_length), DW'(5));
        chk("t1_data", out_data, DW'(40'h0504030201));
        chk("t1_error", DW'(out_error), DW'(0));
        @(negedge clk);
        chk("t1_one_cycle", DW'(out_valid), DW'(0));

        // Fill and overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send(16'(i), rnd_data(), 1'b0);
            if (i == 4) chk("t2_full", DW'(full), DW'(1));
            if (i >= 5) chk("t2_overflow", DW'(overflow), DW'(1));
        end
        @(negedge clk);
        chk("t2_overflow_clear", DW'(overflow), DW'(0));
        chk("t2_drop_count", DW'(drop_count), DW'(2));
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_order", DW'(out_length), DW'(k));
            @(negedge clk);
        end
        chk("t2_empty", DW'(occupancy), DW'(0));

        // Full queue with simultaneous pop and push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(11 + i), rnd_data(), 1'b0);
        chk("t3_full", DW'(full), DW'(1));
        out_ready = 1'b1;
        send(16'd9, rnd_data(), 1'b0);
        chk("t3_no_overflow", DW'(overflow), DW'(0));
        chk("t3_occupancy", DW'(occupancy), DW'(4));
        t3_exp = '{16'd12, 16'd13, 16'd14, 16'd9};
        for (int k = 0; k < 4; k++) begin
            chk("t3_order", DW'(out_length), DW'(t3_exp[k]));
            @(negedge clk);
        end
        chk("t3_empty", DW'(occupancy), DW'(0));

        // Length sanitisation and error discard
        send(16'd0, rnd_data(), 1'b0);
        chk("t4_len0_error", DW'(out_error), DW'(1));
        chk("t4_len0_data", out_data, DW'(0));
        send(16'(MB + 1), '1, 1'b0);
        chk("t4_long_error", DW'(out_error), DW'(1));
        chk("t4_long_length", DW'(out_length), DW'(MB + 1));
        chk("t4_long_data", out_data, {DW{1'b1}});
        send(16'd5, rnd_data(), 1'b1);
        chk("t4_de_no_output", DW'(e_out_valid), DW'(0));
        chk("t4_de_err_drops", DW'(e_err_drop_count), DW'(1));
        chk("t4_kept_error", DW'(out_error), DW'(1));
        @(negedge clk);

        // Random traffic under random backpressure
        sent = 0;
        while (sent < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                send(16'($urandom_range(0, 40)), rnd_data(), 1'($urandom_range(0, 9) == 0));
                sent++;
            end else begin
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_drained", DW'(occupancy), DW'(0));

        // Asynchronous reset with messages queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(7 + i), rnd_data(), 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", DW'(out_valid), DW'(0));
        chk("t6_occupancy", DW'(occupancy), DW'(0));
        chk("t6_length", DW'(out_length), DW'(0));
        chk("t6_data", out_data, DW'(0));
        chk("t6_error", DW'(out_error), DW'(0));
        chk("t6_drop_count", DW'(drop_count), DW'(0));
        chk("t6_de_err_drops", DW'(e_err_drop_count), DW'(0));
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        d = rnd_data();
        exp_d = '0;
        exp_d[23:0] = d[23:0];
        send(16'd3, d, 1'b0);
        chk("t6_after_valid", DW'(out_valid), DW'(1));
        chk("t6_after_length", DW'(out_length), DW'(3));
        chk("t6_after_data", out_data, exp_d);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
